// File: rtl/dfswt_frame_ctrl_if.sv
// Sample-in and result-out valid/ready bundle for the DFSWT frame controller.
// master = sample source / result consumer side, slave = controller side.
interface dfswt_frame_ctrl_if #(
    parameter int unsigned CHBITS = 2
) ();
    logic                     sample_valid;
    logic signed [15:0]       sample_in;
    logic                     sample_ready;
    logic signed [31:0]       result_data;
    logic        [CHBITS-1:0] result_chan;
    logic                     result_valid;
    logic                     result_ready;

    modport master (
        output sample_valid, sample_in, result_ready,
        input  sample_ready, result_data, result_chan, result_valid
    );

    modport slave (
        input  sample_valid, sample_in, result_ready,
        output sample_ready, result_data, result_chan, result_valid
    );
endinterface

// File: rtl/dfswt_frame_ctrl.sv
// Frame sequencer for a DFSWT stage bank: clear, gate POINTS samples, snapshot
// every stage accumulator, then drain the snapshots one channel per handshake.
module dfswt_frame_ctrl #(
    parameter int unsigned POINTS   = 8,
    parameter int unsigned CNTBITS  = 3,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CHBITS   = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic                      continuous_i,
    dfswt_frame_ctrl_if.slave         bus,
    output logic                      stage_clear_o,
    output logic                      stage_enable_o,
    output logic signed [15:0]        stage_data_o,
    input  logic [32*CHANNELS-1:0]    acc_in_i,
    output logic                      busy_o,
    output logic                      overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_FLUSH,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t                state_q;
    logic [CNTBITS-1:0]    count_q;
    logic [CHBITS-1:0]     chan_q;
    logic [31:0]           snap_q [CHANNELS];
    logic                  ready_q;
    logic                  clear_q;
    logic                  enable_q;
    logic signed [15:0]    data_q;
    logic                  valid_q;
    logic signed [31:0]    result_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic                  accept;
    logic                  handshake;
    logic                  last_sample;
    logic                  last_chan;
    logic [CHBITS-1:0]     chan_nxt;

    always_comb begin
        accept      = bus.sample_valid & ready_q;
        handshake   = valid_q & bus.result_ready;
        last_sample = (count_q == CNTBITS'(POINTS - 1));
        last_chan   = (chan_q == CHBITS'(CHANNELS - 1));
        chan_nxt    = chan_q + CHBITS'(1);
    end

    // Every output is a flop, updated alongside the state transition that implies it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            chan_q    <= '0;
            ready_q   <= 1'b0;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                snap_q[c] <= '0;
            end
        end else begin
            enable_q <= 1'b0;
            if (state_q != S_IDLE && bus.sample_valid && !ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_CLEAR;
                        clear_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_ACCUM;
                    clear_q <= 1'b0;
                    ready_q <= 1'b1;
                    count_q <= '0;
                end
                S_ACCUM: begin
                    if (accept) begin
                        enable_q <= 1'b1;
                        data_q   <= bus.sample_in;
                        if (last_sample) begin
                            count_q <= '0;
                            ready_q <= 1'b0;
                            state_q <= S_FLUSH;
                        end else begin
                            count_q <= count_q + CNTBITS'(1);
                        end
                    end
                end
                // Lets the stages absorb the final enable before their accumulators are sampled.
                S_FLUSH: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        snap_q[c] <= acc_in_i[32*c +: 32];
                    end
                    result_q <= acc_in_i[31:0];
                    chan_q   <= '0;
                    valid_q  <= 1'b1;
                    state_q  <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (handshake) begin
                        if (!last_chan) begin
                            chan_q   <= chan_nxt;
                            result_q <= snap_q[chan_nxt];
                        end else begin
                            valid_q <= 1'b0;
                            chan_q  <= '0;
                            if (continuous_i) begin
                                state_q <= S_CLEAR;
                                clear_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.result_data  = result_q;
    assign bus.result_chan  = chan_q;
    assign bus.result_valid = valid_q;
    assign stage_clear_o    = clear_q;
    assign stage_enable_o   = enable_q;
    assign stage_data_o     = data_q;
    assign busy_o           = busy_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_dfswt_frame_ctrl.sv
// Directed bench for dfswt_frame_ctrl with stub accumulator stages and a result scoreboard.
module tb_dfswt_frame_ctrl;
    localparam int unsigned POINTS   = 8;
    localparam int unsigned CNTBITS  = 3;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CHBITS   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   continuous = 1'b0;
    logic                   stage_clear;
    logic                   stage_enable;
    logic signed [15:0]     stage_data;
    logic [32*CHANNELS-1:0] acc_in;
    logic                   busy;
    logic                   overrun;

    dfswt_frame_ctrl_if #(.CHBITS(CHBITS)) bus ();

    dfswt_frame_ctrl #(
        .POINTS(POINTS), .CNTBITS(CNTBITS), .CHANNELS(CHANNELS), .CHBITS(CHBITS)
    ) dut (
        .clock(clk), .reset_n(rst_n), .start_i(start), .continuous_i(continuous),
        .bus(bus.slave), .stage_clear_o(stage_clear), .stage_enable_o(stage_enable),
        .stage_data_o(stage_data), .acc_in_i(acc_in), .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // Stub stages: channel c accumulates (c+1) * stage_data so channels are distinguishable.
    logic signed [31:0] acc [CHANNELS];
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (stage_clear)       acc[c] <= '0;
            else if (stage_enable) acc[c] <= acc[c] + 32'(stage_data) * (c + 1);
        end
    end
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) acc_in[32*c +: 32] = acc[c];
    end

    typedef struct {
        logic [CHBITS-1:0] chan;
        logic [31:0]       data;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] smp [POINTS];
    int                 cur_sum;
    int                 vectors = 0;
    int                 miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every result handshake pops one expected (chan, data).
    always @(negedge clk) begin
        if (rst_n && bus.result_valid && bus.result_ready) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_empty observed=result chan %0d expected=no result", bus.result_chan);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("result_chan", 32'(bus.result_chan), 32'(e.chan));
                chk("result_data", bus.result_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready"},  32'(bus.sample_ready), 0);
        chk({pfx, "_clear"},  32'(stage_clear), 0);
        chk({pfx, "_enable"}, 32'(stage_enable), 0);
        chk({pfx, "_sdata"},  stage_data, 0);
        chk({pfx, "_rdata"},  bus.result_data, 0);
        chk({pfx, "_rchan"},  32'(bus.result_chan), 0);
        chk({pfx, "_rvalid"}, 32'(bus.result_valid), 0);
        chk({pfx, "_busy"},   32'(busy), 0);
        chk({pfx, "_overrun"}, 32'(overrun), 0);
    endtask

    // Called #1 into a CLEAR cycle; steps into the first ACCUM cycle.
    task automatic clear_then_accum();
        chk("clear_pulse", 32'(stage_clear), 1);
        chk("clear_busy", 32'(busy), 1);
        chk("clear_ready", 32'(bus.sample_ready), 0);
        tick();
        chk("accum_clear_off", 32'(stage_clear), 0);
        chk("accum_ready", 32'(bus.sample_ready), 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_overrun_cleared", 32'(overrun), 0);
        clear_then_accum();
    endtask

    task automatic feed(input bit gap, input int npts, output int got);
        int  n = 0;
        int  guard = 0;
        bit  acc_seen;
        while (n < npts && guard < 64) begin
            bus.sample_valid = gap ? ((guard % 2) == 0) : 1'b1;
            bus.sample_in    = bus.sample_valid ? smp[n] : 16'sh5a5a;
            @(negedge clk);
            acc_seen = bus.sample_valid && bus.sample_ready;
            tick();
            if (acc_seen) begin
                chk("en_after_accept", 32'(stage_enable), 1);
                chk("stage_data", stage_data, smp[n]);
                n++;
            end else begin
                chk("en_no_accept", 32'(stage_enable), 0);
            end
            guard++;
        end
        bus.sample_valid = 1'b0;
        got = n;
    endtask

    task automatic push_exp();
        exp_t e;
        cur_sum = 0;
        for (int i = 0; i < POINTS; i++) cur_sum += int'(smp[i]);
        for (int c = 0; c < CHANNELS; c++) begin
            e.chan = CHBITS'(c);
            e.data = 32'(cur_sum * (c + 1));
            sb.push_back(e);
        end
    endtask

    // Called #1 into FLUSH (the cycle after the last accept); ends in the first DRAIN cycle.
    task automatic flush_capture();
        chk("flush_ready", 32'(bus.sample_ready), 0);
        chk("flush_busy", 32'(busy), 1);
        chk("flush_rvalid", 32'(bus.result_valid), 0);
        tick();
        chk("capture_enable", 32'(stage_enable), 0);
        chk("capture_rvalid", 32'(bus.result_valid), 0);
        tick();
        chk("drain_rvalid", 32'(bus.result_valid), 1);
    endtask

    task automatic drain(input int bp_chan, input int bp_len, input bit ovr_poke);
        int hs = 0;
        int guard = 0;
        int stall = 0;
        while (hs < CHANNELS && guard < 64) begin
            if (int'(bus.result_chan) == bp_chan && stall < bp_len) begin
                bus.result_ready = 1'b0;
                stall++;
            end else begin
                bus.result_ready = 1'b1;
            end
            bus.sample_valid = ovr_poke && (hs == 1);
            @(negedge clk);
            if (!bus.result_ready) begin
                chk("bp_chan", 32'(bus.result_chan), 32'(bp_chan));
                chk("bp_data", bus.result_data, 32'(cur_sum * (bp_chan + 1)));
            end
            if (bus.result_valid && bus.result_ready) hs++;
            tick();
            guard++;
        end
        bus.result_ready = 1'b0;
        bus.sample_valid = 1'b0;
        chk("drain_handshakes", 32'(hs), CHANNELS);
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    int got;

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.result_ready = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Basic frame: samples 1..8
        for (int i = 0; i < POINTS; i++) smp[i] = 16'(i + 1);
        do_start();
        feed(1'b0, POINTS, got);
        chk("basic_count", 32'(got), POINTS);
        push_exp();
        chk("basic_sum", 32'(cur_sum), 36);
        flush_capture();
        drain(-1, 0, 1'b0);
        chk("basic_end_busy", 32'(busy), 0);
        chk("basic_end_rvalid", 32'(bus.result_valid), 0);
        chk("basic_end_overrun", 32'(overrun), 0);

        // Gapped input with mixed-sign samples
        for (int i = 0; i < POINTS; i++) smp[i] = 16'(i * 3 - 7);
        do_start();
        feed(1'b1, POINTS, got);
        chk("gap_count", 32'(got), POINTS);
        push_exp();
        flush_capture();

        // Backpressure at chan 2; a start pulse during drain must be ignored
        start = 1'b1;
        drain(2, 5, 1'b0);
        start = 1'b0;
        chk("bp_end_busy", 32'(busy), 0);
        chk("bp_end_clear", 32'(stage_clear), 0);

        // Overrun: sample offered during drain
        for (int i = 0; i < POINTS; i++) smp[i] = 16'(100 - i * 17);
        do_start();
        feed(1'b0, POINTS, got);
        push_exp();
        flush_capture();
        drain(-1, 0, 1'b1);
        chk("ovr_set_idle", 32'(overrun), 1);
        tick();
        tick();
        chk("ovr_sticky", 32'(overrun), 1);

        // Continuous: -100 frame then 32767 frame back to back
        continuous = 1'b1;
        for (int i = 0; i < POINTS; i++) smp[i] = -16'sd100;
        do_start();
        feed(1'b0, POINTS, got);
        push_exp();
        chk("cont1_sum", 32'(cur_sum), 32'(-800));
        flush_capture();
        drain(-1, 0, 1'b0);
        continuous = 1'b0;
        clear_then_accum();
        for (int i = 0; i < POINTS; i++) smp[i] = 16'sd32767;
        feed(1'b0, POINTS, got);
        push_exp();
        chk("cont2_sum", 32'(cur_sum), 262136);
        flush_capture();
        drain(-1, 0, 1'b0);
        chk("cont_end_busy", 32'(busy), 0);

        // Reset mid-ACCUM after 5 samples, then a clean frame
        for (int i = 0; i < POINTS; i++) smp[i] = 16'(50 + i);
        do_start();
        feed(1'b0, 5, got);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < POINTS; i++) smp[i] = 16'(10 + i);
        do_start();
        feed(1'b0, POINTS, got);
        push_exp();
        chk("post_reset_sum", 32'(cur_sum), 108);
        flush_capture();
        drain(-1, 0, 1'b0);
        chk("post_reset_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
